// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: HC-SR04-class trigger generator and echo-width meter.
// Fires one trigger per fixed period, times the echo high phase in osc
// cycles and publishes the width (all-ones on timeout) with a one-cycle
// valid strobe. too_close is a registered compare of the published width.
//
// state | meaning
// IDLE  | single cycle after reset before the first trigger
// TRIG  | trigger pulse high; timer counts the pulse width down
// WAIT  | trigger low; waiting for an echo rising edge or the timeout
// MEAS  | echo high; meas_cnt counts the echo width
// HOLD  | result published; waiting for the period counter to expire
module ultrasonic_ranger #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned PERIOD_CYCLES  = 3_000_000,
    parameter int unsigned STOP_THRESH    = 58_000
) (
    input  logic        osc,
    input  logic        reset,
    input  logic        echo,
    output logic        trig,
    output logic [31:0] echo_cnt,
    output logic        valid,
    output logic        timeout,
    output logic        too_close
);

    localparam logic [31:0] TRIG_LOAD    = 32'(TRIG_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LIM  = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
    localparam logic [31:0] STOP_LIM     = 32'(STOP_THRESH);
    localparam logic [31:0] CNT_NONE     = 32'hFFFF_FFFF;
    localparam logic [31:0] CNT_SAT      = 32'hFFFF_FFFE;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT, MEAS, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] meas_cnt_q, meas_cnt_d;
    logic [31:0] period_cnt_q, period_cnt_d;
    logic [31:0] echo_cnt_q, echo_cnt_d;
    logic        trig_q, trig_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;
    logic        too_close_q, too_close_d;
    logic        echo_meta_q, echo_meta_d;
    logic        echo_s_q, echo_s_d;
    logic        echo_d_q, echo_d_d;
    logic        rise, fall;

    assign rise = echo_s_q & ~echo_d_q;
    assign fall = ~echo_s_q & echo_d_q;

    // Next-state and output computation for the measurement sequencer.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        meas_cnt_d   = meas_cnt_q;
        period_cnt_d = (period_cnt_q == PERIOD_LAST) ? period_cnt_q : period_cnt_q + 32'd1;
        echo_cnt_d   = echo_cnt_q;
        trig_d       = trig_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;
        too_close_d  = (echo_cnt_q <= STOP_LIM);
        echo_meta_d  = echo;
        echo_s_d     = echo_meta_q;
        echo_d_d     = echo_s_q;

        case (state_q)
            IDLE: begin
                state_d      = TRIG;
                trig_d       = 1'b1;
                timer_d      = TRIG_LOAD;
                period_cnt_d = 32'd0;
            end
            TRIG: begin
                if (timer_q == 32'd0) begin
                    state_d = WAIT;
                    trig_d  = 1'b0;
                    timer_d = TIMEOUT_LOAD;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            WAIT: begin
                // A level already high on entry is not an edge and is ignored.
                if (rise) begin
                    meas_cnt_d = 32'd1;
                    state_d    = MEAS;
                end else if (timer_q == 32'd0) begin
                    echo_cnt_d = CNT_NONE;
                    valid_d    = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = HOLD;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            MEAS: begin
                if (fall) begin
                    echo_cnt_d = meas_cnt_q;
                    valid_d    = 1'b1;
                    timeout_d  = 1'b0;
                    state_d    = HOLD;
                end else if (meas_cnt_q >= TIMEOUT_LIM) begin
                    echo_cnt_d = CNT_NONE;
                    valid_d    = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = HOLD;
                end else if (echo_s_q && (meas_cnt_q != CNT_SAT)) begin
                    meas_cnt_d = meas_cnt_q + 32'd1;
                end
            end
            HOLD: begin
                if (period_cnt_q == PERIOD_LAST) begin
                    state_d      = TRIG;
                    trig_d       = 1'b1;
                    timer_d      = TRIG_LOAD;
                    period_cnt_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, synchroniser and output registers with synchronous reset.
    always_ff @(posedge osc) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= 32'd0;
            meas_cnt_q   <= 32'd0;
            period_cnt_q <= 32'd0;
            echo_cnt_q   <= CNT_NONE;
            trig_q       <= 1'b0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            too_close_q  <= 1'b0;
            echo_meta_q  <= 1'b0;
            echo_s_q     <= 1'b0;
            echo_d_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            meas_cnt_q   <= meas_cnt_d;
            period_cnt_q <= period_cnt_d;
            echo_cnt_q   <= echo_cnt_d;
            trig_q       <= trig_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            too_close_q  <= too_close_d;
            echo_meta_q  <= echo_meta_d;
            echo_s_q     <= echo_s_d;
            echo_d_q     <= echo_d_d;
        end
    end

    assign trig      = trig_q;
    assign echo_cnt  = echo_cnt_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign too_close = too_close_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: directed scenarios for the ultrasonic ranger with
// small timing parameters; expected values are hand-computed constants.
module tb_ultrasonic_ranger;

    localparam int unsigned TRIG_C = 10;
    localparam int unsigned TO_C   = 100;
    localparam int unsigned PER_C  = 300;
    localparam int unsigned THR    = 20;
    localparam logic [31:0] NONE   = 32'hFFFF_FFFF;

    logic        osc = 1'b0;
    logic        reset = 1'b1;
    logic        echo = 1'b0;
    logic        trig;
    logic [31:0] echo_cnt;
    logic        valid;
    logic        timeout;
    logic        too_close;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int double_valid = 0;
    logic valid_prev = 1'b0;

    ultrasonic_ranger #(
        .TRIG_CYCLES(TRIG_C),
        .TIMEOUT_CYCLES(TO_C),
        .PERIOD_CYCLES(PER_C),
        .STOP_THRESH(THR)
    ) dut (
        .osc(osc),
        .reset(reset),
        .echo(echo),
        .trig(trig),
        .echo_cnt(echo_cnt),
        .valid(valid),
        .timeout(timeout),
        .too_close(too_close)
    );

    always #5 osc = ~osc;

    always @(posedge osc) cyc <= cyc + 1;

    always @(negedge osc) begin
        if (valid && valid_prev) double_valid++;
        valid_prev = valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus helpers only: they drive or wait, they do not judge.
    task automatic wait_valid(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge osc);
            if (valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_trig_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * PER_C; i++) begin
            if (trig === 1'b1) break;
            @(negedge osc);
        end
        for (int i = 0; i < 2 * PER_C; i++) begin
            if (trig !== 1'b1) break;
            @(negedge osc);
        end
        ok = (trig === 1'b0);
    endtask

    task automatic drive_pulse(input int delay, input int width);
        repeat (delay) @(negedge osc);
        echo = 1'b1;
        repeat (width) @(negedge osc);
        echo = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        echo  = 1'b0;
        repeat (3) @(negedge osc);
        vectors++; if (trig !== 1'b0) begin miscompares++; $display("FAIL reset_trig: got %b want 0", trig); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        vectors++; if (too_close !== 1'b0) begin miscompares++; $display("FAIL reset_too_close: got %b want 0", too_close); end
        vectors++; if (echo_cnt !== NONE) begin miscompares++; $display("FAIL reset_echo_cnt: got %h want %h", echo_cnt, NONE); end
        reset = 1'b0;
    endtask

    task automatic test_no_echo();
        int hi;
        int n;
        int c_rise1;
        int c_rise2;
        @(negedge osc);
        vectors++; if (trig !== 1'b1) begin miscompares++; $display("FAIL idle_one_cycle: trig got %b want 1", trig); end
        c_rise1 = cyc;
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            if (trig !== 1'b1) break;
            hi++;
            @(negedge osc);
        end
        vectors++; if (hi != 10) begin miscompares++; $display("FAIL trig_width: got %0d want 10", hi); end
        wait_valid(200, n);
        vectors++; if (n != 100) begin miscompares++; $display("FAIL wait_timeout_delay: got %0d want 100", n); end
        vectors++; if (echo_cnt !== NONE) begin miscompares++; $display("FAIL wait_timeout_cnt: got %h want %h", echo_cnt, NONE); end
        vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL wait_timeout_flag: got %b want 1", timeout); end
        @(negedge osc);
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL valid_one_cycle: got %b want 0", valid); end
        vectors++; if (too_close !== 1'b0) begin miscompares++; $display("FAIL timeout_too_close: got %b want 0", too_close); end
        for (int i = 0; i < 400; i++) begin
            if (trig === 1'b1) break;
            @(negedge osc);
        end
        c_rise2 = cyc;
        vectors++; if (c_rise2 - c_rise1 != 300) begin miscompares++; $display("FAIL period: got %0d want 300", c_rise2 - c_rise1); end
    endtask

    task automatic test_echo_50();
        bit ok;
        int n;
        wait_trig_fall(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL trig_fall_50: got no fall want fall"); end
        drive_pulse(5, 50);
        wait_valid(10, n);
        vectors++; if (n != 3) begin miscompares++; $display("FAIL latency_50: got %0d want 3", n); end
        vectors++; if (echo_cnt !== 32'd50) begin miscompares++; $display("FAIL echo_cnt_50: got %0d want 50", echo_cnt); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_50: got %b want 0", timeout); end
        @(negedge osc);
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL valid_once_50: got %b want 0", valid); end
        vectors++; if (too_close !== 1'b0) begin miscompares++; $display("FAIL too_close_50: got %b want 0", too_close); end
    endtask

    task automatic test_too_close();
        bit ok;
        int n;
        wait_trig_fall(ok);
        drive_pulse(5, 15);
        wait_valid(10, n);
        vectors++; if (echo_cnt !== 32'd15) begin miscompares++; $display("FAIL echo_cnt_15: got %0d want 15", echo_cnt); end
        vectors++; if (too_close !== 1'b0) begin miscompares++; $display("FAIL too_close_lag_15: got %b want 0", too_close); end
        @(negedge osc);
        vectors++; if (too_close !== 1'b1) begin miscompares++; $display("FAIL too_close_15: got %b want 1", too_close); end
        wait_trig_fall(ok);
        drive_pulse(5, 25);
        wait_valid(10, n);
        vectors++; if (echo_cnt !== 32'd25) begin miscompares++; $display("FAIL echo_cnt_25: got %0d want 25", echo_cnt); end
        vectors++; if (too_close !== 1'b1) begin miscompares++; $display("FAIL too_close_lag_25: got %b want 1", too_close); end
        @(negedge osc);
        vectors++; if (too_close !== 1'b0) begin miscompares++; $display("FAIL too_close_25: got %b want 0", too_close); end
        wait_trig_fall(ok);
        drive_pulse(5, 12);
        wait_valid(10, n);
        vectors++; if (echo_cnt !== 32'd12) begin miscompares++; $display("FAIL echo_cnt_12: got %0d want 12", echo_cnt); end
        @(negedge osc);
        vectors++; if (too_close !== 1'b1) begin miscompares++; $display("FAIL too_close_12: got %b want 1", too_close); end
    endtask

    task automatic test_echo_stuck_high();
        bit ok;
        int n;
        echo = 1'b1;
        wait_trig_fall(ok);
        wait_valid(200, n);
        vectors++; if (n != 100) begin miscompares++; $display("FAIL stuck_delay: got %0d want 100", n); end
        vectors++; if (echo_cnt !== NONE) begin miscompares++; $display("FAIL stuck_cnt: got %h want %h", echo_cnt, NONE); end
        vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL stuck_timeout: got %b want 1", timeout); end
        @(negedge osc);
        vectors++; if (too_close !== 1'b0) begin miscompares++; $display("FAIL stuck_too_close: got %b want 0", too_close); end
        echo = 1'b0;
        wait_trig_fall(ok);
        drive_pulse(5, 30);
        wait_valid(10, n);
        vectors++; if (echo_cnt !== 32'd30) begin miscompares++; $display("FAIL echo_cnt_30: got %0d want 30", echo_cnt); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_clear_30: got %b want 0", timeout); end
    endtask

    task automatic test_meas_timeout();
        bit ok;
        int n;
        int extra;
        wait_trig_fall(ok);
        repeat (5) @(negedge osc);
        echo = 1'b1;
        wait_valid(200, n);
        vectors++; if (n != 103) begin miscompares++; $display("FAIL meas_timeout_delay: got %0d want 103", n); end
        vectors++; if (echo_cnt !== NONE) begin miscompares++; $display("FAIL meas_timeout_cnt: got %h want %h", echo_cnt, NONE); end
        vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL meas_timeout_flag: got %b want 1", timeout); end
        extra = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge osc);
            if (valid === 1'b1) extra++;
            echo = (i < 24) ? (((i / 4) % 2) == 0) : 1'b0;
            if (trig === 1'b1) break;
        end
        vectors++; if (extra != 0) begin miscompares++; $display("FAIL hold_edges_valid: got %0d want 0", extra); end
        vectors++; if (trig !== 1'b1) begin miscompares++; $display("FAIL hold_next_trig: got %b want 1", trig); end
    endtask

    task automatic test_reset_mid_meas();
        bit ok;
        int n;
        int hi;
        int stale;
        wait_trig_fall(ok);
        drive_pulse(5, 10);
        wait_valid(10, n);
        @(negedge osc);
        vectors++; if (too_close !== 1'b1) begin miscompares++; $display("FAIL pre_reset_too_close: got %b want 1", too_close); end
        wait_trig_fall(ok);
        repeat (5) @(negedge osc);
        echo = 1'b1;
        repeat (20) @(negedge osc);
        reset = 1'b1;
        @(negedge osc);
        reset = 1'b0;
        vectors++; if (trig !== 1'b0) begin miscompares++; $display("FAIL mid_reset_trig: got %b want 0", trig); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b want 0", valid); end
        vectors++; if (echo_cnt !== NONE) begin miscompares++; $display("FAIL mid_reset_cnt: got %h want %h", echo_cnt, NONE); end
        vectors++; if (too_close !== 1'b0) begin miscompares++; $display("FAIL mid_reset_too_close: got %b want 0", too_close); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL mid_reset_timeout: got %b want 0", timeout); end
        @(negedge osc);
        vectors++; if (trig !== 1'b1) begin miscompares++; $display("FAIL post_reset_idle: trig got %b want 1", trig); end
        echo = 1'b0;
        hi = 0;
        stale = 0;
        for (int i = 0; i < 50; i++) begin
            if (trig !== 1'b1) break;
            hi++;
            if (valid === 1'b1) stale++;
            @(negedge osc);
        end
        vectors++; if (hi != 10) begin miscompares++; $display("FAIL post_reset_trig_width: got %0d want 10", hi); end
        vectors++; if (stale != 0) begin miscompares++; $display("FAIL post_reset_stale_valid: got %0d want 0", stale); end
        wait_valid(200, n);
        vectors++; if (n != 100) begin miscompares++; $display("FAIL post_reset_timeout: got %0d want 100", n); end
    endtask

    initial begin
        test_reset();
        test_no_echo();
        test_echo_50();
        test_too_close();
        test_echo_stuck_high();
        test_meas_timeout();
        test_reset_mid_meas();
        repeat (2) @(negedge osc);
        vectors++; if (double_valid != 0) begin miscompares++; $display("FAIL back_to_back_valid: got %0d want 0", double_valid); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
